// File: rtl/qspi_arbiter.sv
// Transaction-granular round-robin arbiter sharing one QSPI controller between m0 and m1.
// Optional watchdog abort when QSPI_ARB_TIMEOUT_EN is defined.
module qspi_arbiter #(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned ADDR_W         = 25,
  parameter int unsigned LEN_W          = 8,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clock,
  input  logic              rstn,
  input  logic              m0_req,
  input  logic              m1_req,
  input  logic              m0_we,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [LEN_W-1:0]  m0_len,
  input  logic [LEN_W-1:0]  m1_len,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m0_stall,
  input  logic              m1_stall,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic              m0_wdata_req,
  output logic              m1_wdata_req,
  output logic              m0_rdata_valid,
  output logic              m1_rdata_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              m0_done,
  output logic              m1_done,
  output logic              m0_err,
  output logic              m1_err,
  output logic [ADDR_W-1:0] q_addr,
  output logic [DATA_W-1:0] q_wdata,
  output logic              q_start_read,
  output logic              q_start_write,
  output logic              q_stall,
  output logic              q_stop,
  input  logic [DATA_W-1:0] q_rdata,
  input  logic              q_data_req,
  input  logic              q_data_ready,
  input  logic              q_busy
);

  typedef enum logic [2:0] {StIdle, StStart, StXfer, StStop, StDrain} state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_owner_q, last_owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rvalid_q, rvalid_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        done_q, done_d;
  logic [1:0]        wreq;
  logic              winner;
  logic              beat;
  logic              owner_stall;
  logic [DATA_W-1:0] owner_wdata;

`ifdef QSPI_ARB_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [WdW-1:0] wd_q, wd_d;
  logic           abort_q, abort_d;
  logic [1:0]     err_q, err_d;
`endif

  assign owner_stall = owner_q ? m1_stall : m0_stall;
  assign owner_wdata = owner_q ? m1_wdata : m0_wdata;

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_owner_d  = last_owner_q;
    we_d          = we_q;
    addr_d        = addr_q;
    cnt_d         = cnt_q;
    rdata_d       = rdata_q;
    wdata_d       = wdata_q;
    rvalid_d      = 1'b0;
    gnt_d         = 2'b00;
    done_d        = 2'b00;
    wreq          = 2'b00;
    winner        = 1'b0;
    beat          = 1'b0;
    q_start_read  = 1'b0;
    q_start_write = 1'b0;
    q_stall       = 1'b0;
    q_stop        = 1'b0;
    q_wdata       = wdata_q;
`ifdef QSPI_ARB_TIMEOUT_EN
    wd_d          = wd_q;
    abort_d       = abort_q;
    err_d         = 2'b00;
`endif
    unique case (state_q)
      StIdle: begin
        if (!q_busy && (m0_req || m1_req)) begin
          // On a tie the requester that did not own the last transaction wins.
          winner        = (m0_req && m1_req) ? ~last_owner_q : m1_req;
          owner_d       = winner;
          last_owner_d  = winner;
          we_d          = winner ? m1_we : m0_we;
          addr_d        = winner ? m1_addr : m0_addr;
          cnt_d         = winner ? m1_len : m0_len;
          gnt_d[winner] = 1'b1;
`ifdef QSPI_ARB_TIMEOUT_EN
          abort_d       = 1'b0;
`endif
          state_d       = StStart;
        end
      end
      StStart: begin
        q_start_write = we_q;
        q_start_read  = ~we_q;
`ifdef QSPI_ARB_TIMEOUT_EN
        wd_d          = '0;
`endif
        state_d       = StXfer;
      end
      StXfer: begin
        q_stall = owner_stall;
        beat    = we_q ? q_data_req : q_data_ready;
        if (beat) begin
          if (we_q) begin
            q_wdata      = owner_wdata;
            wdata_d      = owner_wdata;
            wreq[owner_q] = 1'b1;
          end else begin
            rdata_d  = q_rdata;
            rvalid_d = 1'b1;
          end
          if (cnt_q == '0) state_d = StStop;
          else             cnt_d   = cnt_q - 1'b1;
        end
`ifdef QSPI_ARB_TIMEOUT_EN
        if (beat) begin
          wd_d = '0;
        end else if (wd_q == WdW'(TIMEOUT_CYCLES - 1)) begin
          abort_d = 1'b1;
          state_d = StStop;
        end else if (!owner_stall) begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end
      StStop: begin
        q_stop  = 1'b1;
        state_d = StDrain;
      end
      StDrain: begin
        if (!q_busy) begin
          done_d[owner_q] = 1'b1;
`ifdef QSPI_ARB_TIMEOUT_EN
          err_d[owner_q]  = abort_q;
`endif
          state_d         = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= '0;
      cnt_q        <= '0;
      rdata_q      <= '0;
      wdata_q      <= '0;
      rvalid_q     <= 1'b0;
      gnt_q        <= 2'b00;
      done_q       <= 2'b00;
`ifdef QSPI_ARB_TIMEOUT_EN
      wd_q         <= '0;
      abort_q      <= 1'b0;
      err_q        <= 2'b00;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      rdata_q      <= rdata_d;
      wdata_q      <= wdata_d;
      rvalid_q     <= rvalid_d;
      gnt_q        <= gnt_d;
      done_q       <= done_d;
`ifdef QSPI_ARB_TIMEOUT_EN
      wd_q         <= wd_d;
      abort_q      <= abort_d;
      err_q        <= err_d;
`endif
    end
  end

  assign q_addr         = addr_q;
  assign rdata          = rdata_q;
  assign m0_gnt         = gnt_q[0];
  assign m1_gnt         = gnt_q[1];
  assign m0_done        = done_q[0];
  assign m1_done        = done_q[1];
  assign m0_wdata_req   = wreq[0];
  assign m1_wdata_req   = wreq[1];
  assign m0_rdata_valid = rvalid_q & ~owner_q;
  assign m1_rdata_valid = rvalid_q & owner_q;
`ifdef QSPI_ARB_TIMEOUT_EN
  assign m0_err = err_q[0];
  assign m1_err = err_q[1];
`else
  assign m0_err = 1'b0;
  assign m1_err = 1'b0;
`endif

endmodule

// File: tb/tb_qspi_arbiter.sv
// Randomized bench for qspi_arbiter: the bench plays both requesters and the QSPI controller,
// predicting grants, strobes and data from the arbitration rules.
module tb_qspi_arbiter;
  localparam int AW = 25;
  localparam int LW = 8;

  logic          clock = 1'b0;
  logic          rstn;
  logic          m0_req, m1_req, m0_we, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [LW-1:0] m0_len, m1_len;
  logic [7:0]    m0_wdata, m1_wdata;
  logic          m0_stall, m1_stall;
  logic          m0_gnt, m1_gnt, m0_wdata_req, m1_wdata_req, m0_rdata_valid, m1_rdata_valid;
  logic [7:0]    rdata;
  logic          m0_done, m1_done, m0_err, m1_err;
  logic [AW-1:0] q_addr;
  logic [7:0]    q_wdata;
  logic          q_start_read, q_start_write, q_stall, q_stop;
  logic [7:0]    q_rdata;
  logic          q_data_req, q_data_ready, q_busy;

  always #5 clock = ~clock;

  qspi_arbiter dut (
    .clock(clock), .rstn(rstn),
    .m0_req(m0_req), .m1_req(m1_req), .m0_we(m0_we), .m1_we(m1_we),
    .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_len(m0_len), .m1_len(m1_len),
    .m0_wdata(m0_wdata), .m1_wdata(m1_wdata), .m0_stall(m0_stall), .m1_stall(m1_stall),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_wdata_req(m0_wdata_req), .m1_wdata_req(m1_wdata_req),
    .m0_rdata_valid(m0_rdata_valid), .m1_rdata_valid(m1_rdata_valid), .rdata(rdata),
    .m0_done(m0_done), .m1_done(m1_done), .m0_err(m0_err), .m1_err(m1_err),
    .q_addr(q_addr), .q_wdata(q_wdata), .q_start_read(q_start_read),
    .q_start_write(q_start_write), .q_stall(q_stall), .q_stop(q_stop),
    .q_rdata(q_rdata), .q_data_req(q_data_req), .q_data_ready(q_data_ready), .q_busy(q_busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic finish_up();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({m0_gnt, m1_gnt, m0_wdata_req, m1_wdata_req, m0_rdata_valid, m1_rdata_valid,
                rdata, m0_done, m1_done, m0_err, m1_err, q_addr, q_wdata,
                q_start_read, q_start_write, q_stall, q_stop});
  endfunction

  // Requester model: pending flag and the transaction each master wants.
  bit            pend[2];
  bit            mwe[2];
  logic [AW-1:0] maddr[2];
  int            mlen[2];
  logic [7:0]    mdat[2][8];
  bit            last_owner;

  // Per-transaction context used by the cycle task.
  int         owner;
  bit         cur_we;
  bit         in_xfer;
  bit         busy_drv;
  bit         rv_pend;
  logic [7:0] rv_byte;

  task automatic new_params(input int m);
    pend[m]  = 1'b1;
    mwe[m]   = bit'($urandom_range(1, 0));
    maddr[m] = AW'($urandom);
    mlen[m]  = int'($urandom_range(7, 0));
    for (int i = 0; i < 8; i++) mdat[m][i] = 8'($urandom);
  endtask

  task automatic drive_reqs();
    m0_req = pend[0]; m0_we = mwe[0]; m0_addr = maddr[0]; m0_len = LW'(mlen[0]);
    m1_req = pend[1]; m1_we = mwe[1]; m1_addr = maddr[1]; m1_len = LW'(mlen[1]);
  endtask

  // One clock of controller/requester activity, then checks of every strobe in that cycle.
  task automatic cyc(input bit beat, input int idx, input bit exp_stop);
    logic [7:0] b;
    bit         ostall;
    @(posedge clock); #1;
    drive_reqs();
    q_busy   = busy_drv;
    m0_stall = bit'($urandom_range(1, 0));
    m1_stall = bit'($urandom_range(1, 0));
    m0_wdata = 8'($urandom);
    m1_wdata = 8'($urandom);
    b = mdat[owner][idx];
    if (beat && cur_we) begin
      if (owner == 0) m0_wdata = b;
      else            m1_wdata = b;
    end
    q_data_req   = beat & cur_we;
    q_data_ready = beat & ~cur_we;
    q_rdata      = (beat && !cur_we) ? b : 8'($urandom);
    ostall       = (owner == 0) ? m0_stall : m1_stall;
    @(negedge clock);
    check("q_stall", 64'(q_stall), 64'(in_xfer & ostall));
    check("wdata_req", 64'({m1_wdata_req, m0_wdata_req}),
          (beat && cur_we) ? 64'(1) << owner : 64'(0));
    if (beat && cur_we) check("q_wdata", 64'(q_wdata), 64'(b));
    check("rdata_valid", 64'({m1_rdata_valid, m0_rdata_valid}),
          rv_pend ? 64'(1) << owner : 64'(0));
    if (rv_pend) check("rdata", 64'(rdata), 64'(rv_byte));
    rv_pend = beat & ~cur_we;
    rv_byte = b;
    check("q_stop", 64'(q_stop), 64'(exp_stop));
    check("quiet", 64'({m1_gnt, m0_gnt, m1_done, m0_done, q_start_read, q_start_write}), 64'(0));
  endtask

  initial begin
    int  prev_owner;
    int  hold;
    int  w;
    bit  got;
    int  k;
    rstn = 1'b0;
    m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0; m0_addr = '0; m1_addr = '0;
    m0_len = '0; m1_len = '0; m0_wdata = '0; m1_wdata = '0; m0_stall = 0; m1_stall = 0;
    q_rdata = '0; q_data_req = 0; q_data_ready = 0; q_busy = 0;
    pend[0] = 0; pend[1] = 0;
    for (int m = 0; m < 2; m++) begin
      mwe[m] = 0; maddr[m] = '0; mlen[m] = 0;
      for (int i = 0; i < 8; i++) mdat[m][i] = '0;
    end
    #12;
    check("reset_outs", all_outs(), 64'(0));
    rstn = 1'b1;
    last_owner = 1'b1;
    prev_owner = -1;

    for (int it = 0; it < 40; it++) begin
      // Cycle in which the previous done is visible and arbitration is evaluated.
      @(posedge clock); #1;
      if (it == 0) begin
        pend[0] = 1; mwe[0] = 0; maddr[0] = AW'(25'h000100); mlen[0] = 3;
        for (int i = 0; i < 4; i++) mdat[0][i] = 8'hA0 + 8'(i);
      end else if (it == 1) begin
        new_params(1); mwe[1] = 1; mlen[1] = 1; mdat[1][0] = 8'h5A; mdat[1][1] = 8'hC3;
      end else if (it == 2) begin
        new_params(0); new_params(1);
      end else begin
        for (int m = 0; m < 2; m++) if (!pend[m] && $urandom_range(1, 0) == 1) new_params(m);
        if (!pend[0] && !pend[1]) new_params(int'($urandom_range(1, 0)));
      end
      hold = (it >= 4 && $urandom_range(3, 0) == 0) ? 3 : 0;
      q_busy = (hold != 0);
      q_data_req = 0; q_data_ready = 0;
      drive_reqs();
      @(negedge clock);
      if (prev_owner >= 0) begin
        check("done", 64'({m1_done, m0_done}), 64'(1) << prev_owner);
        check("err", 64'({m1_err, m0_err}), 64'(0));
      end
      check("gnt_early", 64'({m1_gnt, m0_gnt}), 64'(0));
      for (int h = 0; h < hold; h++) begin
        check("gnt_busy", 64'({m1_gnt, m0_gnt}), 64'(0));
        @(posedge clock); #1;
        if (h == hold - 1) q_busy = 0;
        @(negedge clock);
      end

      w = (pend[0] && pend[1]) ? int'(!last_owner) : int'(pend[1]);
      got = 0;
      k = 0;
      while (k < 10 && !got) begin
        @(posedge clock); #1;
        @(negedge clock);
        if (m0_gnt || m1_gnt) got = 1;
        else k++;
      end
      if (!got) begin
        check("gnt_timeout", 64'(0), 64'(1));
        finish_up();
      end
      check("gnt_lat", 64'(k), 64'(0));
      check("gnt", 64'({m1_gnt, m0_gnt}), 64'(1) << w);
      check("start", 64'({q_start_write, q_start_read}), mwe[w] ? 64'(2) : 64'(1));
      check("q_addr", 64'(q_addr), 64'(maddr[w]));
      last_owner = bit'(w);
      pend[w]    = 0;
      owner      = w;
      cur_we     = mwe[w];
      busy_drv   = 1;
      in_xfer    = 1;
      rv_pend    = 0;
      for (int i = 0; i <= mlen[w]; i++) begin
        int gaps = int'($urandom_range(2, 0));
        for (int g = 0; g < gaps; g++) cyc(1'b0, 0, 1'b0);
        cyc(1'b1, i, 1'b0);
      end
      in_xfer = 0;
      cyc(1'b0, 0, 1'b1);
      hold = int'($urandom_range(3, 0));
      for (int d = 0; d < hold; d++) cyc(1'b0, 0, 1'b0);
      busy_drv = 0;
      cyc(1'b0, 0, 1'b0);
      prev_owner = w;
    end

    @(posedge clock); #1;
    pend[0] = 0; pend[1] = 0;
    drive_reqs();
    q_busy = 0;
    @(negedge clock);
    check("done_last", 64'({m1_done, m0_done}), 64'(1) << prev_owner);

    // Reset in the middle of an m0 read, then the first tie must go to m0 again.
    @(posedge clock); #1;
    m0_req = 1; m0_we = 0; m0_addr = AW'(25'h000200); m0_len = 8'd3;
    @(posedge clock); #1;
    @(negedge clock);
    check("rst_pre_gnt", 64'({m1_gnt, m0_gnt}), 64'(1));
    @(posedge clock); #1;
    m0_req = 0; q_busy = 1; q_data_ready = 1; q_rdata = 8'h77;
    @(posedge clock); #1;
    q_data_ready = 0;
    @(negedge clock);
    check("rst_pre_rv", 64'(m0_rdata_valid), 64'(1));
    #2 rstn = 1'b0;
    #1 check("async_rst", all_outs(), 64'(0));
    @(posedge clock); #1;
    rstn = 1'b1; q_busy = 0; m0_req = 1; m1_req = 1;
    @(posedge clock); #1;
    @(negedge clock);
    check("rst_tie", 64'({m1_gnt, m0_gnt}), 64'(1));
    finish_up();
  end
endmodule

// File: doc/qspi_arbiter.md
Name: qspi_arbiter

Overview:
- Shares the single QSPI controller (flash / RAM A / RAM B) between two requesters: m0 (instruction fetch) and m1 (data/memory-controller side).
- Transaction-granular round-robin: a winner owns the controller from start pulse to stop and busy-low.
- Sits between the requesters and the QSPI controller command interface. It latches the address, direction and length, counts beats, and routes data/handshake strobes to the owner.

Parameters:
- DATA_W, 8, byte width of data paths
- ADDR_W, 25, QSPI address width (upper bits select device inside the QSPI controller)
- LEN_W, 8, burst length field; beats = len+1 (1..256)
- TIMEOUT_CYCLES, 64, watchdog limit (used only with optional feature)

Ports:
- clock  in  1  system clock, rising edge
- rstn  in  1  asynchronous active-low reset
- m0_req / m1_req  in  1  transaction request; hold until gnt
- m0_we / m1_we  in  1  1=write, 0=read
- m0_addr / m1_addr  in  ADDR_W  start address
- m0_len / m1_len  in  LEN_W  beats-1
- m0_wdata / m1_wdata  in  DATA_W  write byte; valid in the cycle its wdata_req is high
- m0_stall / m1_stall  in  1  owner backpressure, forwarded to stall_txn
- m0_gnt / m1_gnt  out  1  one-cycle grant pulse
- m0_wdata_req / m1_wdata_req  out  1  write byte consumed this cycle
- m0_rdata_valid / m1_rdata_valid  out  1  rdata valid this cycle
- rdata  out  DATA_W  read byte (shared, qualified by rdata_valid)
- m0_done / m1_done  out  1  one-cycle completion pulse
- m0_err / m1_err  out  1  timeout abort, coincident with done (0 without feature)
- q_addr  out  ADDR_W  to controller addr_in
- q_wdata  out  DATA_W  to controller data_in
- q_start_read / q_start_write  out  1  start pulses
- q_stall  out  1  to stall_txn
- q_stop  out  1  to stop_txn
- q_rdata  in  DATA_W  from data_out
- q_data_req  in  1  controller wants next write byte
- q_data_ready  in  1  read byte valid
- q_busy  in  1  controller busy

Behaviour:
- Reset: state IDLE; all outputs 0; q_addr=0; beat counter=0; last_owner=1 (so m0 wins the first tie).
- States: IDLE, START, XFER, STOP, DRAIN.
- IDLE:
  - If q_busy=0 and any req: pick the sole requester. If both request, pick the one != last_owner.
  - Latch addr/we/len into internal regs and cnt=len. Pulse winner gnt. Set owner and last_owner. -> START.
  - No grant while q_busy=1.
- START:
  - Exactly one cycle of q_start_write (we=1) or q_start_read (we=0); q_addr=latched addr.
  - q_data_ready / q_data_req in this cycle are ignored. -> XFER.
- XFER:
  - q_stall = owner stall, combinational; the non-owner stall is ignored.
  - Read: on q_data_ready, rdata=q_rdata registered, so owner rdata_valid is high the next cycle (1-cycle latency).
  - Write: on q_data_req, q_wdata=owner wdata and owner wdata_req=1 in the same cycle (combinational).
  - Each beat: if cnt==0 -> STOP, else cnt-=1.
  - Beats arriving while the owner stalls are still accepted and counted.
- STOP: q_stop=1 for one cycle -> DRAIN.
- DRAIN:
  - Wait until q_busy=0, then pulse owner done (err if aborted) and return to IDLE.
  - The earliest new grant is the cycle after done.
- Requests:
  - req dropped before gnt is withdrawn; no side effects.
  - The owner's req is ignored from gnt until done.
  - The non-owner's req stays pending and wins at the next IDLE (round-robin guarantees no starvation).
- Outputs: q_addr/q_wdata hold their last values outside use. Only q_start_*, q_stop, gnt, done, err, wdata_req and rdata_valid are pulses.
- Reset mid-transaction: immediate return to reset state. No q_stop is issued; the QSPI controller shares rstn.

Optional Feature:
- QSPI_ARB_TIMEOUT_EN defined:
  - A watchdog counter clears on START and on each beat, and increments in XFER while owner stall=0.
  - On reaching TIMEOUT_CYCLES-1: go to STOP; the done pulse is accompanied by err=1.
- Undefined: no watchdog; err outputs tied 0; a transaction waits indefinitely for beats.

Test Plan:
- m0 read, addr=0x000100, len=3; controller returns 0xA0..0xA3 -> one gnt, one q_start_read with q_addr=0x000100, four m0_rdata_valid with 0xA0..0xA3, one q_stop after fourth beat, m0_done after q_busy falls.
- m1 write, len=1, wdata 0x5A then 0xC3 -> q_start_write; each q_data_req yields m1_wdata_req and q_wdata equal to the current byte; q_stop after 2nd beat.
- m0 and m1 both request from reset, then both re-request -> order m0, m1, m0, m1; no gnt while q_busy=1.
- m1 stalls 3 cycles mid-read, len=0 -> q_stall mirrors m1_stall; m0_stall toggling has no effect; single beat delivered; done.
- rstn asserted during XFER of m0 -> all outputs 0 asynchronously; after release the first tie again goes to m0.
- With QSPI_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, no q_data_ready after start -> q_stop 8 cycles after START, then done+err together; without the macro, no q_stop.
